cmp3_sort4_ctrl: RTL and testbench

Sequencing controller that sorts four 3-bit unsigned values using a single shared 3-bit magnitude comparator (one `comp3m2` instance, outputs gt/eq/lt). Runs an in-place bubble sort of at most 6 compare-and-swap steps, one step per clock. It sits between a producer that presents a packed 4-element vector with a start pulse and a consumer that takes the sorted vector on a one-cycle done strobe.

---
 rtl/cmp3_sort4_ctrl.sv | 164 ++++++++++++++++
 tb/tb_cmp3_sort4_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmp3_sort4_ctrl.sv
// ============================================================================
// Module   : cmp3_sort4_ctrl (with helper comp3m2)
// Brief    : Bubble-sorts four 3-bit values through one shared magnitude
//            comparator, one compare-and-swap step per clock.
//            Optional macro CMP3_SORT_EARLY_EXIT_EN ends the sort at a pass
//            boundary when that pass made no swap.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module comp3m2 (
  input  logic [2:0] a,
  input  logic [2:0] b,
  output logic       gt,
  output logic       eq,
  output logic       lt
);
  assign gt = (a > b);
  assign eq = (a == b);
  assign lt = (a < b);
endmodule

module cmp3_sort4_ctrl #(
  parameter bit DIR = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [11:0] din,
  output logic        busy,
  output logic        done,
  output logic [11:0] dout,
  output logic [2:0]  swaps
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMP  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_e [4];
  logic [2:0]  w_e_nxt [4];
  logic [2:0]  r_s;
  logic [2:0]  r_cnt;
  logic [2:0]  w_cnt_nxt;
  logic        r_pass_swapped;
  logic [11:0] r_dout;
  logic [2:0]  r_swaps;
  logic [1:0]  w_ia;
  logic [2:0]  w_a;
  logic [2:0]  w_b;
  logic        w_gt;
  logic        w_eq;
  logic        w_lt;
  logic        w_swap;
  logic        w_boundary;
  logic        w_finish;

  // Step index selects the lower element of the compared pair.
  always_comb begin
    case (r_s)
      3'd1, 3'd4: w_ia = 2'd1;
      3'd2:       w_ia = 2'd2;
      default:    w_ia = 2'd0;
    endcase
  end

  assign w_a = r_e[w_ia];
  assign w_b = r_e[w_ia + 2'd1];

  comp3m2 u_cmp (
    .a  (w_a),
    .b  (w_b),
    .gt (w_gt),
    .eq (w_eq),
    .lt (w_lt)
  );

  generate
    if (DIR) begin : g_desc
      assign w_swap = ~w_eq & w_lt;
    end else begin : g_asc
      assign w_swap = ~w_eq & w_gt;
    end
  endgenerate

  always_comb begin
    for (int k = 0; k < 4; k++) w_e_nxt[k] = r_e[k];
    if (w_swap) begin
      w_e_nxt[w_ia]        = w_b;
      w_e_nxt[w_ia + 2'd1] = w_a;
    end
  end

  assign w_cnt_nxt  = r_cnt + {2'b00, w_swap};
  assign w_boundary = (r_s == 3'd2) || (r_s == 3'd4);

`ifdef CMP3_SORT_EARLY_EXIT_EN
  // A pass without any swap means the vector is already in order.
  assign w_finish = (r_s == 3'd5) || (w_boundary && !(r_pass_swapped || w_swap));
`else
  assign w_finish = (r_s == 3'd5);
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_nxt = ST_CMP;
      ST_CMP:  if (w_finish) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) r_e[k] <= 3'd0;
      r_s            <= 3'd0;
      r_cnt          <= 3'd0;
      r_pass_swapped <= 1'b0;
      r_dout         <= 12'd0;
      r_swaps        <= 3'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            for (int k = 0; k < 4; k++) r_e[k] <= din[3*k +: 3];
            r_s            <= 3'd0;
            r_cnt          <= 3'd0;
            r_pass_swapped <= 1'b0;
          end
        end
        ST_CMP: begin
          r_e            <= w_e_nxt;
          r_s            <= r_s + 3'd1;
          r_cnt          <= w_cnt_nxt;
          r_pass_swapped <= w_boundary ? 1'b0 : (r_pass_swapped | w_swap);
          // Result is captured on the final step so it is valid with done.
          if (w_finish) begin
            r_dout  <= {w_e_nxt[3], w_e_nxt[2], w_e_nxt[1], w_e_nxt[0]};
            r_swaps <= w_cnt_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy  = (r_state == ST_CMP);
  assign done  = (r_state == ST_DONE);
  assign dout  = r_dout;
  assign swaps = r_swaps;

endmodule

`default_nettype wire

// File: tb/tb_cmp3_sort4_ctrl.sv
// ============================================================================
// Module   : tb_cmp3_sort4_ctrl
// Brief    : Directed and exhaustive self-checking bench for cmp3_sort4_ctrl,
//            ascending and descending instances side by side.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cmp3_sort4_ctrl;

`ifdef CMP3_SORT_EARLY_EXIT_EN
  localparam int LAT_SORTED = 3;
  localparam int LAT_P1     = 5;
`else
  localparam int LAT_SORTED = 6;
  localparam int LAT_P1     = 6;
`endif

  logic        clk;
  logic        rst;
  logic        start;
  logic [11:0] din;
  logic        busy0, done0, busy1, done1;
  logic [11:0] dout0, dout1;
  logic [2:0]  swaps0, swaps1;
  int          checks;
  int          failures;

  cmp3_sort4_ctrl #(.DIR(1'b0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .din(din),
    .busy(busy0), .done(done0), .dout(dout0), .swaps(swaps0)
  );

  cmp3_sort4_ctrl #(.DIR(1'b1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .din(din),
    .busy(busy1), .done(done1), .dout(dout1), .swaps(swaps1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rank-placement sort; latency follows from the largest backward displacement.
  function automatic void ref_sort(input logic [11:0] d, input bit desc,
                                   output logic [11:0] srt, output logic [2:0] inv,
                                   output int lat);
    logic [2:0] e [4];
    logic [2:0] o [4];
    int rank, c, p, tot;
    for (int i = 0; i < 4; i++) e[i] = d[3*i +: 3];
    p = 0;
    tot = 0;
    for (int i = 0; i < 4; i++) begin
      rank = 0;
      c = 0;
      for (int j = 0; j < 4; j++) begin
        if (desc ? (e[j] > e[i]) : (e[j] < e[i])) rank++;
        else if (e[j] == e[i] && j < i) rank++;
        if (j < i && (desc ? (e[j] < e[i]) : (e[j] > e[i]))) c++;
      end
      o[rank] = e[i];
      tot += c;
      if (c > p) p = c;
    end
    srt = {o[3], o[2], o[1], o[0]};
    inv = 3'(tot);
    lat = (p == 0) ? LAT_SORTED : (p == 1) ? LAT_P1 : 6;
  endfunction

  task automatic run_sort(input logic [11:0] d, output int lat0, output int lat1);
    @(negedge clk);
    din   = d;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat0 = 0;
    lat1 = 0;
    for (int k = 1; k <= 12 && (lat0 == 0 || lat1 == 0); k++) begin
      @(posedge clk); #1;
      if (done0 && lat0 == 0) lat0 = k;
      if (done1 && lat1 == 0) lat1 = k;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    din   = 12'd0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy0 !== 1'b0 || done0 !== 1'b0 || dout0 !== 12'd0 || swaps0 !== 3'd0) begin
      failures++;
      $display("FAIL reset_dut0 busy=%b done=%b dout=%o swaps=%0d expected 0/0/0/0",
               busy0, done0, dout0, swaps0);
    end
    checks++;
    if (busy1 !== 1'b0 || done1 !== 1'b0 || dout1 !== 12'd0 || swaps1 !== 3'd0) begin
      failures++;
      $display("FAIL reset_dut1 busy=%b done=%b dout=%o swaps=%0d expected 0/0/0/0",
               busy1, done1, dout1, swaps1);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reverse();
    int l0, l1;
    run_sort(12'o1357, l0, l1);
    checks++;
    if (dout0 !== 12'o7531 || swaps0 !== 3'd6 || l0 != 6) begin
      failures++;
      $display("FAIL reverse_asc dout=%o swaps=%0d lat=%0d expected 7531/6/6", dout0, swaps0, l0);
    end
    checks++;
    if (dout1 !== 12'o1357 || swaps1 !== 3'd0 || l1 != LAT_SORTED) begin
      failures++;
      $display("FAIL reverse_desc dout=%o swaps=%0d lat=%0d expected 1357/0/%0d",
               dout1, swaps1, l1, LAT_SORTED);
    end
  endtask

  task automatic test_sorted();
    int l0, l1;
    run_sort(12'o7531, l0, l1);
    checks++;
    if (dout0 !== 12'o7531 || swaps0 !== 3'd0 || l0 != LAT_SORTED) begin
      failures++;
      $display("FAIL sorted_asc dout=%o swaps=%0d lat=%0d expected 7531/0/%0d",
               dout0, swaps0, l0, LAT_SORTED);
    end
    checks++;
    if (dout1 !== 12'o1357 || swaps1 !== 3'd6 || l1 != 6) begin
      failures++;
      $display("FAIL sorted_desc dout=%o swaps=%0d lat=%0d expected 1357/6/6", dout1, swaps1, l1);
    end
  endtask

  task automatic test_equal();
    int l0, l1;
    run_sort(12'o3333, l0, l1);
    checks++;
    if (dout0 !== 12'o3333 || swaps0 !== 3'd0 || l0 != LAT_SORTED) begin
      failures++;
      $display("FAIL equal_all_asc dout=%o swaps=%0d lat=%0d expected 3333/0/%0d",
               dout0, swaps0, l0, LAT_SORTED);
    end
    checks++;
    if (dout1 !== 12'o3333 || swaps1 !== 3'd0 || l1 != LAT_SORTED) begin
      failures++;
      $display("FAIL equal_all_desc dout=%o swaps=%0d lat=%0d expected 3333/0/%0d",
               dout1, swaps1, l1, LAT_SORTED);
    end
    // e0=4 e1=2 e2=4 e3=2: three inversions ascending, one descending.
    run_sort(12'o2424, l0, l1);
    checks++;
    if (dout0 !== 12'o4422 || swaps0 !== 3'd3 || l0 != 6) begin
      failures++;
      $display("FAIL pairs_asc dout=%o swaps=%0d lat=%0d expected 4422/3/6", dout0, swaps0, l0);
    end
    checks++;
    if (dout1 !== 12'o2244 || swaps1 !== 3'd1 || l1 != LAT_P1) begin
      failures++;
      $display("FAIL pairs_desc dout=%o swaps=%0d lat=%0d expected 2244/1/%0d",
               dout1, swaps1, l1, LAT_P1);
    end
  endtask

  task automatic test_start_while_busy();
    int ndone;
    logic [11:0] got;
    logic [2:0]  gsw;
    ndone = 0;
    got   = 12'd0;
    gsw   = 3'd0;
    @(negedge clk);
    din   = 12'o1357;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    din   = 12'o7531;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 14; k++) begin
      @(posedge clk); #1;
      if (done0) begin
        ndone++;
        got = dout0;
        gsw = swaps0;
      end
    end
    checks++;
    if (ndone != 1) begin
      failures++;
      $display("FAIL busy_start_done_count got=%0d expected 1", ndone);
    end
    checks++;
    if (got !== 12'o7531 || gsw !== 3'd6) begin
      failures++;
      $display("FAIL busy_start_result dout=%o swaps=%0d expected 7531/6", got, gsw);
    end
  endtask

  task automatic test_reset_mid_sort();
    int ndone, l0, l1;
    ndone = 0;
    @(negedge clk);
    din   = 12'o1357;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (busy0 !== 1'b1) begin
      failures++;
      $display("FAIL mid_sort_busy got=%b expected 1", busy0);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (busy0 !== 1'b0 || done0 !== 1'b0 || dout0 !== 12'd0 || swaps0 !== 3'd0) begin
      failures++;
      $display("FAIL abort_state busy=%b done=%b dout=%o swaps=%0d expected 0/0/0/0",
               busy0, done0, dout0, swaps0);
    end
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (done0 || done1) ndone++;
    end
    checks++;
    if (ndone != 0) begin
      failures++;
      $display("FAIL abort_no_done got=%0d expected 0", ndone);
    end
    run_sort(12'o1357, l0, l1);
    checks++;
    if (dout0 !== 12'o7531 || swaps0 !== 3'd6 || l0 != 6) begin
      failures++;
      $display("FAIL after_abort dout=%o swaps=%0d lat=%0d expected 7531/6/6", dout0, swaps0, l0);
    end
  endtask

  task automatic test_exhaustive();
    int l0, l1, el0, el1;
    logic [11:0] d, s0, s1;
    logic [2:0]  i0, i1;
    for (int v = 0; v < 4096; v++) begin
      d = 12'(v);
      ref_sort(d, 1'b0, s0, i0, el0);
      ref_sort(d, 1'b1, s1, i1, el1);
      run_sort(d, l0, l1);
      checks++;
      if (dout0 !== s0 || swaps0 !== i0 || l0 != el0) begin
        failures++;
        $display("FAIL exh_asc din=%o dout=%o swaps=%0d lat=%0d expected %o/%0d/%0d",
                 d, dout0, swaps0, l0, s0, i0, el0);
      end
      checks++;
      if (dout1 !== s1 || swaps1 !== i1 || l1 != el1) begin
        failures++;
        $display("FAIL exh_desc din=%o dout=%o swaps=%0d lat=%0d expected %o/%0d/%0d",
                 d, dout1, swaps1, l1, s1, i1, el1);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_reverse();
    test_sorted();
    test_equal();
    test_start_while_busy();
    test_reset_mid_sort();
    test_exhaustive();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
